// File: rtl/aibcr3_red_ctrl_pkg.sv
// Shared types and constants for the redundancy clock-mux select controller.
// Holds the FSM state encoding, the delay counter width and parameter defaults.
package aibcr3_red_ctrl_pkg;

    localparam int CNT_W          = 4;
    localparam int SW_CNT_W       = 8;
    localparam int DEF_QUIET_CYC  = 4;
    localparam int DEF_SETTLE_CYC = 8;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_GATE   = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

endpackage

// File: rtl/aibcr3_red_dly_cnt.sv
// Loadable down-counter shared by all timed controller phases.
// Ports: clk, rst_n, load/load_val (load wins), dec (stops at 0), zero flag.
module aibcr3_red_dly_cnt
    import aibcr3_red_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/aibcr3_red_clksel_ctrl.sv
// Sequences shift_en/jtag_clksel changes for the redundancy clock mux:
// gate clocks, wait QUIET_CYC, switch selects, wait SETTLE_CYC, ungate, ack.
// Ports: clk, rst_n, cfg_req/cfg_shift_en/cfg_jtag_clksel in, cfg_ack, busy,
// shift_en, jtag_clksel, clk_gate_en out. AIBCR3_RED_CTRL_STATS_EN adds
// sw_clr (in) and sw_count (out, saturating count of changing requests).
module aibcr3_red_clksel_ctrl
    import aibcr3_red_ctrl_pkg::*;
#(
    parameter int QUIET_CYC  = DEF_QUIET_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_req,
    input  logic                cfg_shift_en,
    input  logic                cfg_jtag_clksel,
    output logic                cfg_ack,
    output logic                busy,
    output logic                shift_en,
    output logic                jtag_clksel,
    output logic                clk_gate_en
`ifdef AIBCR3_RED_CTRL_STATS_EN
    ,
    input  logic                sw_clr,
    output logic [SW_CNT_W-1:0] sw_count
`endif
);

    if ((QUIET_CYC < 1) || (QUIET_CYC > 15)) begin : g_bad_quiet
        $fatal(1, "QUIET_CYC out of range 1..15");
    end
    if ((SETTLE_CYC < 1) || (SETTLE_CYC > 15)) begin : g_bad_settle
        $fatal(1, "SETTLE_CYC out of range 1..15");
    end

    localparam logic [CNT_W-1:0] QUIET_LD  = CNT_W'(QUIET_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] pend_q;

    logic       cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic       cnt_dec;
    logic       cnt_zero;

    logic       ack_d;
    logic       capture;
    logic       apply;
    logic       gate_on;
    logic       gate_off;
    logic       done_chg;

    aibcr3_red_dly_cnt #(
        .RST_VAL (SETTLE_LD)
    ) u_dly_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        ack_d    = 1'b0;
        capture  = 1'b0;
        apply    = 1'b0;
        gate_on  = 1'b0;
        gate_off = 1'b0;
        done_chg = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    gate_on = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_IDLE: begin
                // The ack cycle itself never accepts: the requester is
                // still holding cfg_req high while it observes the ack.
                if (cfg_req && !cfg_ack) begin
                    if ({cfg_shift_en, cfg_jtag_clksel}
                        == {shift_en, jtag_clksel}) begin
                        ack_d = 1'b1;
                    end else begin
                        capture  = 1'b1;
                        gate_off = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = QUIET_LD;
                        state_d  = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                if (cnt_zero) begin
                    apply    = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = SETTLE_LD;
                    state_d  = ST_SETTLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    gate_on  = 1'b1;
                    ack_d    = 1'b1;
                    done_chg = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            pend_q      <= 2'b00;
            shift_en    <= 1'b0;
            jtag_clksel <= 1'b0;
            clk_gate_en <= 1'b0;
            cfg_ack     <= 1'b0;
            busy        <= 1'b1;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != ST_IDLE);
            cfg_ack <= ack_d;
            if (capture) begin
                pend_q <= {cfg_shift_en, cfg_jtag_clksel};
            end
            // Both selects move on one edge while clocks are gated.
            if (apply) begin
                shift_en    <= pend_q[1];
                jtag_clksel <= pend_q[0];
            end
            if (gate_off) begin
                clk_gate_en <= 1'b0;
            end else if (gate_on) begin
                clk_gate_en <= 1'b1;
            end
        end
    end

`ifdef AIBCR3_RED_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_count <= '0;
        end else if (sw_clr) begin
            sw_count <= '0;
        end else if (done_chg && (sw_count != '1)) begin
            sw_count <= sw_count + 1'b1;
        end
    end
`else
    logic unused_done_chg;
    assign unused_done_chg = done_chg;
`endif

endmodule

// File: tb/tb_aibcr3_red_clksel_ctrl.sv
// Self-checking bench for aibcr3_red_clksel_ctrl: vector table of requests,
// scoreboard queue of expected acks, plus reset and stats corner sequences.
module tb_aibcr3_red_clksel_ctrl;

`ifdef AIBCR3_RED_CTRL_STATS_EN
    localparam int Q = 1;
    localparam int S = 1;
`else
    localparam int Q = 4;
    localparam int S = 8;
`endif
    localparam int LAT_CHG = 1 + Q + S;

    typedef struct {
        bit s;
        bit j;
        int lat;
        int tog_at;
    } vec_t;

    typedef struct {
        bit s;
        bit j;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic cfg_req;
    logic cfg_shift_en;
    logic cfg_jtag_clksel;
    logic cfg_ack;
    logic busy;
    logic shift_en;
    logic jtag_clksel;
    logic clk_gate_en;
`ifdef AIBCR3_RED_CTRL_STATS_EN
    logic       sw_clr;
    logic [7:0] sw_count;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    bit   m_s = 1'b0;
    bit   m_j = 1'b0;
    int   m_cnt = 0;
    logic p_s = 1'b0;
    logic p_j = 1'b0;

    always #5 clk = ~clk;

    aibcr3_red_clksel_ctrl #(
        .QUIET_CYC  (Q),
        .SETTLE_CYC (S)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_req         (cfg_req),
        .cfg_shift_en    (cfg_shift_en),
        .cfg_jtag_clksel (cfg_jtag_clksel),
        .cfg_ack         (cfg_ack),
        .busy            (busy),
        .shift_en        (shift_en),
        .jtag_clksel     (jtag_clksel),
        .clk_gate_en     (clk_gate_en)
`ifdef AIBCR3_RED_CTRL_STATS_EN
        ,
        .sw_clr          (sw_clr),
        .sw_count        (sw_count)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Selects may only move while downstream clocks are gated.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ((shift_en !== p_s) || (jtag_clksel !== p_j)))
                chk("gate_vs_sel", int'(clk_gate_en), 0);
            p_s = shift_en;
            p_j = jtag_clksel;
        end
    end

    task automatic do_init();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= S; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == S - 1) begin
                chk("init_gate_low", int'(clk_gate_en), 0);
                chk("init_busy", int'(busy), 1);
            end
            if (i == S) begin
                chk("init_gate_up", int'(clk_gate_en), 1);
                chk("init_idle", int'(busy), 0);
                chk("init_sel", int'({shift_en, jtag_clksel}), 0);
                chk("init_no_ack", int'(cfg_ack), 0);
            end
        end
        m_s = 1'b0;
        m_j = 1'b0;
    endtask

    task automatic do_req(input bit s, input bit j, input int lat,
                          input int tog_at, input bit rst_mid,
                          input bit clr_at_ack);
        exp_t e;
        int   n;
        bit   done;
        @(negedge clk);
        cfg_req         = 1'b1;
        cfg_shift_en    = s;
        cfg_jtag_clksel = j;
        sb.push_back('{s: s, j: j, lat: lat});
        n    = 0;
        done = 1'b0;
        while (!done && n < 64) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (n == tog_at) cfg_shift_en = ~cfg_shift_en;
`ifdef AIBCR3_RED_CTRL_STATS_EN
            if (clr_at_ack && n == lat - 1) sw_clr = 1'b1;
`endif
            if (lat > 1) begin
                if (n == 1) chk("gate_off", int'(clk_gate_en), 0);
                if (n == Q) chk("sel_hold", int'(shift_en), int'(m_s));
                if (n == Q + 1)
                    chk("sel_new", int'({shift_en, jtag_clksel}),
                        int'({s, j}));
                if (rst_mid && n == Q + 2) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_sel", int'({shift_en, jtag_clksel}), 0);
                    chk("rst_gate", int'(clk_gate_en), 0);
                    chk("rst_busy", int'(busy), 1);
                    chk("rst_ack", int'(cfg_ack), 0);
                    cfg_req = 1'b0;
                    void'(sb.pop_front());
                    done = 1'b1;
                end
            end else if (n == 1) begin
                chk("nochg_gate", int'(clk_gate_en), 1);
                chk("nochg_sel", int'({shift_en, jtag_clksel}),
                    int'({m_s, m_j}));
            end
            if (!done && cfg_ack) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_lat", n, e.lat);
                    chk("ack_sel", int'({shift_en, jtag_clksel}),
                        int'({e.s, e.j}));
                    chk("ack_gate", int'(clk_gate_en), 1);
                    chk("ack_busy", int'(busy), 0);
                    if (e.lat > 1 && m_cnt < 255) m_cnt++;
                    m_s = e.s;
                    m_j = e.j;
                end
`ifdef AIBCR3_RED_CTRL_STATS_EN
                if (clr_at_ack) begin
                    m_cnt  = 0;
                    sw_clr = 1'b0;
                end
                chk("sw_count", int'(sw_count), m_cnt);
`endif
                // Request still high through the ack cycle must not re-fire.
                cfg_req = 1'b0;
                done    = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("ack_pulse", int'(cfg_ack), 0);
                chk("no_reaccept", int'(busy), 0);
            end
        end
        if (!done) begin
            chk("ack_timeout", n, lat);
            sb.delete();
            cfg_req = 1'b0;
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{s: 1, j: 0, lat: LAT_CHG, tog_at: 0};
        vecs[1] = '{s: 1, j: 0, lat: 1,       tog_at: 0};
        vecs[2] = '{s: 1, j: 1, lat: LAT_CHG, tog_at: 0};
        vecs[3] = '{s: 0, j: 1, lat: LAT_CHG, tog_at: 2};
        vecs[4] = '{s: 0, j: 1, lat: 1,       tog_at: 0};
        vecs[5] = '{s: 0, j: 0, lat: LAT_CHG, tog_at: 0};
        vecs[6] = '{s: 0, j: 0, lat: 1,       tog_at: 0};

        rst_n           = 1'b0;
        cfg_req         = 1'b0;
        cfg_shift_en    = 1'b0;
        cfg_jtag_clksel = 1'b0;
`ifdef AIBCR3_RED_CTRL_STATS_EN
        sw_clr          = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_sel", int'({shift_en, jtag_clksel}), 0);
        chk("reset_gate", int'(clk_gate_en), 0);
        chk("reset_ack", int'(cfg_ack), 0);
        chk("reset_busy", int'(busy), 1);
        do_init();

        for (int i = 0; i < 7; i++)
            do_req(vecs[i].s, vecs[i].j, vecs[i].lat, vecs[i].tog_at, 0, 0);

`ifndef AIBCR3_RED_CTRL_STATS_EN
        do_req(1, 1, LAT_CHG, 0, 1, 0);
        repeat (2) @(negedge clk);
        chk("rst_hold_gate", int'(clk_gate_en), 0);
        do_init();
        do_req(0, 1, LAT_CHG, 0, 0, 0);
`else
        for (int k = 0; k < 300; k++)
            do_req(~m_s, m_j, LAT_CHG, 0, 0, 0);
        chk("sw_sat", int'(sw_count), 255);
        @(negedge clk);
        sw_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sw_clr = 1'b0;
        m_cnt  = 0;
        chk("sw_clr", int'(sw_count), 0);
        do_req(~m_s, m_j, LAT_CHG, 0, 0, 0);
        do_req(~m_s, m_j, LAT_CHG, 0, 0, 1);
        do_req(m_s, m_j, 1, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
